// File: rtl/led_driver_pkg.sv
// Shared definitions for the LED output engine: channel mode encodings and duty width.
package led_driver_pkg;

    localparam int unsigned DUTY_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } led_mode_e;

endpackage

// File: rtl/led_driver_prescaler.sv
// Shared timebase for all LED channels: prescaler tick, free-running PWM counter
// and the global blink phase.
module led_driver_prescaler
    import led_driver_pkg::*;
#(
    parameter int unsigned PRESCALE  = 1000,
    parameter int unsigned BLINK_DIV = 128
) (
    input  logic              clk,
    input  logic              reset,
    output logic              tick,
    output logic [DUTY_W-1:0] pwm_cnt,
    output logic              phase
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blink_cnt;

    assign tick = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_driver.sv
// Per-channel LED drive: mode/duty config registers written by LOAD, and a
// registered output computed from the shared timebase.
module led_driver
    import led_driver_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = 2,
    parameter int unsigned PRESCALE  = 1000,
    parameter int unsigned BLINK_DIV = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                LOAD,
    input  logic [2:0]          SEL,
    input  logic [1:0]          MODE,
    input  logic [DUTY_W-1:0]   DUTY,
    output logic                TICK,
    output logic [NUM_LEDS-1:0] LED
);

    led_mode_e         mode [NUM_LEDS];
    logic [DUTY_W-1:0] duty [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_next;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              phase;

    led_driver_prescaler #(
        .PRESCALE (PRESCALE),
        .BLINK_DIV(BLINK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .tick   (TICK),
        .pwm_cnt(pwm_cnt),
        .phase  (phase)
    );

    always_comb begin
        led_next = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            case (mode[i])
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_BLINK: led_next[i] = phase;
                MODE_PWM:   led_next[i] = (pwm_cnt < duty[i]);
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    // Out-of-range SEL matches no channel, so such writes fall through untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode[i] <= MODE_OFF;
                duty[i] <= '0;
            end
            LED <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (LOAD && (SEL == 3'(i))) begin
                    mode[i] <= led_mode_e'(MODE);
                    duty[i] <= DUTY;
                end
            end
            LED <= led_next;
        end
    end

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver: two instances (fast blink, fast PWM) share one
// stimulus stream and are checked against cycle-indexed expectations.
module tb_led_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [2:0] sel;
    logic [1:0] mode;
    logic [7:0] duty;
    logic       tick_a, tick_b;
    logic [1:0] led_a, led_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    led_driver #(.NUM_LEDS(2), .PRESCALE(4), .BLINK_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .LOAD(load), .SEL(sel), .MODE(mode),
        .DUTY(duty), .TICK(tick_a), .LED(led_a)
    );

    led_driver #(.NUM_LEDS(2), .PRESCALE(2), .BLINK_DIV(128)) dut_b (
        .clk(clk), .reset(reset), .LOAD(load), .SEL(sel), .MODE(mode),
        .DUTY(duty), .TICK(tick_b), .LED(led_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_cfg(input logic [2:0] s, input logic [1:0] m, input logic [7:0] d);
        load = 1'b1; sel = s; mode = m; duty = d;
        step();
        load = 1'b0;
    endtask

    // Cycles with LED[0] high over one full PWM period, after the new duty is visible.
    task automatic pwm_window(input logic [7:0] d, input int exp_b);
        int cnt_a, cnt_b, exp_a;
        write_cfg(3'd0, 2'b11, d);
        step();
        cnt_a = 0; cnt_b = 0; exp_a = 0;
        for (int n = 0; n < 512; n++) begin
            if (led_a[0]) cnt_a++;
            if (led_b[0]) cnt_b++;
            if ((((cyc - 1) / 4) % 256) < int'(d)) exp_a++;
            step();
        end
        check_eq("pwm_hi_b", 32'(cnt_b), 32'(exp_b));
        check_eq("pwm_hi_a", 32'(cnt_a), 32'(exp_a));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; sel = '0; mode = '0; duty = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;

        // Idle after reset: ticks every 4 (a) / 2 (b) cycles, LEDs dark.
        for (int c = 0; c < 20; c++) begin
            check_eq("idle_tick_a", 32'(tick_a), 32'((c % 4) == 3));
            check_eq("idle_tick_b", 32'(tick_b), 32'((c % 2) == 1));
            check_eq("idle_led_a", 32'(led_a), 32'd0);
            step();
        end
        check_eq("idle_led_b", 32'(led_b), 32'd0);

        // ON then OFF on channel 0, one cycle of output latency.
        write_cfg(3'd0, 2'b01, 8'd0);
        check_eq("on_latency", 32'(led_a), 32'd0);
        step();
        check_eq("on_led_a", 32'(led_a), 32'b01);
        check_eq("on_led_b", 32'(led_b), 32'b01);
        write_cfg(3'd0, 2'b00, 8'd0);
        check_eq("off_latency", 32'(led_a), 32'b01);
        step();
        check_eq("off_led_a", 32'(led_a), 32'd0);

        // Blink on channel 1 follows the global phase (a: 8-cycle half period).
        write_cfg(3'd1, 2'b10, 8'd0);
        step();
        for (int n = 0; n < 40; n++) begin
            check_eq("blink_a", 32'(led_a[1]), 32'(((cyc - 1) / 8) % 2));
            check_eq("blink_b", 32'(led_b[1]), 32'(((cyc - 1) / 256) % 2));
            check_eq("blink_ch0", 32'(led_a[0]), 32'd0);
            step();
        end
        write_cfg(3'd1, 2'b00, 8'd0);
        step();
        check_eq("blink_off", 32'(led_a), 32'd0);

        // PWM duty sweep on channel 0.
        pwm_window(8'd64, 128);
        pwm_window(8'd0, 0);
        pwm_window(8'd255, 510);

        // Out-of-range SEL must be dropped; channel 0 stays PWM at duty 255.
        write_cfg(3'd5, 2'b01, 8'd0);
        step();
        for (int n = 0; n < 4; n++) begin
            check_eq("badsel_led1_a", 32'(led_a[1]), 32'd0);
            check_eq("badsel_led1_b", 32'(led_b[1]), 32'd0);
            check_eq("badsel_led0_b", 32'(led_b[0]), 32'(((cyc - 1) / 2) % 256 < 255));
            step();
        end
        write_cfg(3'd1, 2'b01, 8'd0);
        step();
        check_eq("sel1_on_a", 32'(led_a[1]), 32'd1);
        check_eq("sel1_on_b", 32'(led_b[1]), 32'd1);

        // Reset together with a LOAD: everything clears and the LOAD is lost.
        reset = 1'b1; load = 1'b1; sel = 3'd0; mode = 2'b01; duty = 8'd200;
        step();
        reset = 1'b0; load = 1'b0;
        cyc = 0;
        check_eq("rst_led_a", 32'(led_a), 32'd0);
        check_eq("rst_led_b", 32'(led_b), 32'd0);
        check_eq("rst_tick_a", 32'(tick_a), 32'd0);
        check_eq("rst_tick_b", 32'(tick_b), 32'd0);
        for (int c = 0; c < 10; c++) begin
            check_eq("post_rst_tick_a", 32'(tick_a), 32'((c % 4) == 3));
            check_eq("post_rst_tick_b", 32'(tick_b), 32'((c % 2) == 1));
            check_eq("post_rst_led_a", 32'(led_a), 32'd0);
            check_eq("post_rst_led_b", 32'(led_b), 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_driver.md
Name: led_driver

Overview:
- Sequential GPIO output engine for the board LEDs. It is the output-side counterpart to the button-input path.
- Each LED channel holds a programmable mode (OFF/ON/BLINK/PWM) and an 8-bit duty value.
- All channels run from one shared prescaler tick.
- Sits between Hack top-level logic (or a future memory-mapped GPIO register) and the physical led[] pins.

Parameters:
- NUM_LEDS, 2, number of LED channels (1..8).
- PRESCALE, 1000, clk cycles per tick (>=2).
- BLINK_DIV, 128, ticks per half-period of the blink waveform (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- LOAD  in  1  write strobe; one-cycle pulse writes MODE/DUTY into channel SEL.
- SEL  in  3  target channel index.
- MODE  in  2  00=OFF, 01=ON, 10=BLINK, 11=PWM.
- DUTY  in  8  PWM on-count out of 256.
- TICK  out  1  one-cycle prescaler pulse (debug/test).
- LED  out  NUM_LEDS  registered LED drive, active-high.

Behaviour:
- reset is synchronous and active-high, and has priority over everything, including LOAD.
  - Reset values: all mode regs = OFF, duty regs = 0, prescaler = 0, pwm_cnt = 0, blink_cnt = 0, phase = 0, TICK = 0, LED = 0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps to 0.
  - TICK = 1 for exactly the cycle in which pre_cnt == PRESCALE-1, so the period is PRESCALE cycles.
  - The first TICK after reset is on cycle PRESCALE-1.
  - TICK is combinational from the pre_cnt register.
- PWM counter:
  - 8-bit pwm_cnt increments on each TICK and wraps 255->0 naturally.
- Blink:
  - blink_cnt counts ticks 0..BLINK_DIV-1.
  - On a TICK with blink_cnt == BLINK_DIV-1: blink_cnt -> 0 and phase toggles.
  - phase is global. Entering BLINK does not resynchronise it.
- Config write:
  - On a clk edge with LOAD=1 and SEL < NUM_LEDS, mode[SEL] <= MODE and duty[SEL] <= DUTY.
  - If SEL >= NUM_LEDS, the write is silently dropped and no register changes.
  - Other channels are never disturbed by a write.
- LED output, registered each cycle per channel i:
  - OFF -> 0.
  - ON -> 1.
  - BLINK -> phase.
  - PWM -> (pwm_cnt < duty[i]).
- Latency:
  - LOAD sampled at edge k updates the config at edge k.
  - LED reflects the new mode at edge k+1.
- PWM boundaries:
  - duty = 0 -> LED constantly 0.
  - duty = 255 -> LED high 255 of 256 PWM steps.
  - duty = 128 -> 50%.
  - The compare uses the current pwm_cnt register value; a duty change takes effect mid-period without waiting for wrap.
- Simultaneous events:
  - LOAD coinciding with TICK: the counters advance normally and the config updates.
  - The LED output on the following edge uses the new config and the advanced counters.
- Reset mid-operation: everything returns to reset values on that edge; LED = 0 at the next cycle.
- No state exists outside the listed registers.

Decomposition:
- Shared package/include (led_defs):
  - Mode encodings MODE_OFF=2'b00, MODE_ON=2'b01, MODE_BLINK=2'b10, MODE_PWM=2'b11.
  - DUTY_W=8.
- One natural sub-module: led_prescaler.
  - Holds pre_cnt, TICK, pwm_cnt, blink_cnt and phase.
  - Outputs tick, pwm_cnt and phase.
- The top holds the per-channel config registers and an output generate-loop.

Test Plan:
- Reset, then idle 20 cycles with PRESCALE=4 -> LED=2'b00; TICK high on cycles 3, 7, 11, 15, 19 only.
- LOAD SEL=0 MODE=01 at edge k -> LED[0]=1 from edge k+1; LED[1] stays 0. Then LOAD SEL=0 MODE=00 -> LED[0]=0 one cycle after.
- PRESCALE=4, BLINK_DIV=2, SEL=1 MODE=10 -> LED[1] toggles every 8 clk cycles, aligned to the global phase; 0->1 at the first toggle after reset.
- PRESCALE=2, SEL=0 MODE=11 DUTY=64 over 512 cycles -> LED[0] high exactly 128 cycles. DUTY=0 -> 0 cycles high. DUTY=255 -> 510 cycles high.
- LOAD with SEL=5 (NUM_LEDS=2) MODE=01 -> no LED or config change; a following LOAD SEL=1 MODE=01 works normally.
- Assert reset while channel 0 is in PWM and channel 1 in ON, simultaneously with LOAD -> next cycle LED=0, TICK=0, and the LOAD is ignored. The first TICK comes PRESCALE-1 cycles after reset deasserts.
